// File: rtl/lsu_ctrl_if.sv
// Request, response and memory-port signals of the load/store unit.
interface lsu_ctrl_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic              mem_wen_n;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_waddr;
  logic [ADDR_W-1:0] mem_raddr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  // Execute stage and data memory side.
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_wen_n, mem_funct3, mem_waddr, mem_raddr, mem_wdata
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_wen_n, mem_funct3, mem_waddr, mem_raddr, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: byte-addressed loads/stores to doubleword memory accesses, with
// read-modify-write stores, boundary-crossing splits and load alignment/extension.
module lsu_ctrl #(
  parameter int unsigned ADDR_W = 64
) (
  input  logic    clk,
  input  logic    rst_n,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWr0, StWr1, StResp} state_e;

  state_e state_q, state_d;

  logic              store_q;
  logic [2:0]        funct3_q;
  logic [63:0]       wdata_q;
  logic [2:0]        off_q;
  logic [ADDR_W-1:0] idx0_q;
  logic [ADDR_W-1:0] idx1_q;
  logic              cross_q;
  logic              err_q;
  logic [63:0]       buf0_q;
  logic [63:0]       buf1_q;

  logic              accept;
  logic              req_illegal;
  logic [3:0]        req_size;
  logic              req_cross;
  logic [ADDR_W-1:0] req_idx0;

  logic [15:0]       base_mask;
  logic [15:0]       lane_mask;
  logic [5:0]        shamt;
  logic [127:0]      pair;
  logic [127:0]      wdata_sh;
  logic [127:0]      merged;
  logic [63:0]       load_lo;
  logic [63:0]       load_ext;

  assign accept   = bus.req_valid && (state_q == StIdle);
  assign req_idx0 = {3'b000, bus.req_addr[ADDR_W-1:3]};

  // Request decode: legality, access size and whether it spills into the next doubleword.
  always_comb begin
    req_illegal = bus.req_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
    req_size    = 4'd1;
    case (bus.req_funct3[1:0])
      2'b00:   req_size = 4'd1;
      2'b01:   req_size = 4'd2;
      2'b10:   req_size = 4'd4;
      default: req_size = 4'd8;
    endcase
    req_cross = ({1'b0, bus.req_addr[2:0]} + req_size) > 4'd8;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = req_illegal ? StResp : StRd0;
      StRd0:  state_d = cross_q ? StRd1 : (store_q ? StWr0 : StResp);
      StRd1:  state_d = store_q ? StWr0 : StResp;
      StWr0:  state_d = cross_q ? StWr1 : StResp;
      StWr1:  state_d = StResp;
      StResp: if (bus.resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch and read buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      wdata_q  <= '0;
      off_q    <= 3'b000;
      idx0_q   <= '0;
      idx1_q   <= '0;
      cross_q  <= 1'b0;
      err_q    <= 1'b0;
      buf0_q   <= '0;
      buf1_q   <= '0;
    end else begin
      if (accept) begin
        store_q  <= bus.req_store;
        funct3_q <= bus.req_funct3;
        wdata_q  <= bus.req_wdata;
        off_q    <= bus.req_addr[2:0];
        idx0_q   <= req_idx0;
        idx1_q   <= req_idx0 + {{(ADDR_W-1){1'b0}}, 1'b1};
        cross_q  <= req_cross;
        err_q    <= req_illegal;
      end
      if (state_q == StRd0) buf0_q <= bus.mem_rdata;
      if (state_q == StRd1) buf1_q <= bus.mem_rdata;
    end
  end

  // Byte-lane merge for stores and alignment/extension for loads.
  always_comb begin
    base_mask = 16'h00ff;
    case (funct3_q[1:0])
      2'b00:   base_mask = 16'h0001;
      2'b01:   base_mask = 16'h0003;
      2'b10:   base_mask = 16'h000f;
      default: base_mask = 16'h00ff;
    endcase
    lane_mask = base_mask << off_q;
    shamt     = {off_q, 3'b000};
    pair      = {buf1_q, buf0_q};
    wdata_sh  = {64'h0, wdata_q} << shamt;
    merged    = pair;
    for (int i = 0; i < 16; i++) begin
      if (lane_mask[i]) merged[i*8 +: 8] = wdata_sh[i*8 +: 8];
    end
    load_lo = 64'(pair >> shamt);
    case (funct3_q)
      3'b000:  load_ext = {{56{load_lo[7]}}, load_lo[7:0]};
      3'b001:  load_ext = {{48{load_lo[15]}}, load_lo[15:0]};
      3'b010:  load_ext = {{32{load_lo[31]}}, load_lo[31:0]};
      3'b100:  load_ext = {56'h0, load_lo[7:0]};
      3'b101:  load_ext = {48'h0, load_lo[15:0]};
      3'b110:  load_ext = {32'h0, load_lo[31:0]};
      default: load_ext = load_lo;
    endcase
  end

  // Outputs, decoded from state and latched registers only.
  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.resp_valid = (state_q == StResp);
    bus.resp_err   = (state_q == StResp) && err_q;
    bus.resp_rdata = ((state_q == StResp) && !store_q && !err_q) ? load_ext : 64'h0;
    bus.mem_funct3 = 3'b011;
    bus.mem_wen_n  = 1'b1;
    bus.mem_raddr  = '0;
    bus.mem_waddr  = '0;
    bus.mem_wdata  = merged[63:0];
    case (state_q)
      StRd0: bus.mem_raddr = idx0_q;
      StRd1: bus.mem_raddr = idx1_q;
      StWr0: begin
        bus.mem_wen_n = 1'b0;
        bus.mem_waddr = idx0_q;
      end
      StWr1: begin
        bus.mem_wen_n = 1'b0;
        bus.mem_waddr = idx1_q;
        bus.mem_wdata = merged[127:64];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic clk;
  logic rst_n;

  lsu_ctrl_if #(.ADDR_W(64)) bus ();

  lsu_ctrl #(.ADDR_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 32 doublewords, combinational read, write on rising edge.
  logic [63:0] mem [32];
  logic        pl_en;
  logic [4:0]  pl_idx;
  logic [63:0] pl_data;
  int          wr_count = 0;

  assign bus.mem_rdata = mem[bus.mem_raddr[4:0]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (!bus.mem_wen_n) begin
      mem[bus.mem_waddr[4:0]] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [63:0] val);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_idx  = 5'(idx);
    pl_data = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // One complete transaction; lat counts falling edges after the accept edge
  // until resp_valid is seen.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, output int lat, output logic [63:0] rdata,
                        output logic err, output int writes);
    int w0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    w0 = wr_count;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    rdata = '0;
    err = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) break;
    end
    if (bus.resp_valid) begin
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got no resp_valid, expected one within 20 cycles");
    end
    writes = wr_count - w0;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    int          chk_idx;
    logic [63:0] chk_val;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int          lat;
    int          wr;
    int          w0;
    logic [63:0] rd;
    logic        er;

    vecs[0]  = '{1'b1, 3'b011, 64'h10, 64'h1122334455667788, 64'h0, 1'b0, 3, 1,
                 2, 64'h1122334455667788};
    vecs[1]  = '{1'b0, 3'b000, 64'h10, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 2, 0, -1, 64'h0};
    vecs[2]  = '{1'b0, 3'b100, 64'h10, 64'h0, 64'h88, 1'b0, 2, 0, -1, 64'h0};
    vecs[3]  = '{1'b0, 3'b001, 64'h16, 64'h0, 64'h1122, 1'b0, 2, 0, -1, 64'h0};
    vecs[4]  = '{1'b1, 3'b010, 64'h1E, 64'hAABBCCDD, 64'h0, 1'b0, 5, 2,
                 3, 64'hCCDD000000000000};
    vecs[5]  = '{1'b0, 3'b010, 64'h1E, 64'h0, 64'hFFFFFFFFAABBCCDD, 1'b0, 3, 0,
                 4, 64'h000000000000AABB};
    vecs[6]  = '{1'b0, 3'b110, 64'h1E, 64'h0, 64'h00000000AABBCCDD, 1'b0, 3, 0, -1, 64'h0};
    vecs[7]  = '{1'b1, 3'b000, 64'h0, 64'hDEADBEEF000000FF, 64'h0, 1'b0, 3, 1,
                 0, 64'h0123456789ABCDFF};
    vecs[8]  = '{1'b0, 3'b011, 64'h10, 64'h0, 64'h1122334455667788, 1'b0, 2, 0, -1, 64'h0};
    vecs[9]  = '{1'b0, 3'b001, 64'h1F, 64'h0, 64'hFFFFFFFFFFFFBBCC, 1'b0, 3, 0, -1, 64'h0};
    vecs[10] = '{1'b0, 3'b101, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFF80, 1'b0, 3, 0, -1, 64'h0};
    vecs[11] = '{1'b0, 3'b111, 64'h10, 64'h0, 64'h0, 1'b1, 1, 0, -1, 64'h0};
    vecs[12] = '{1'b1, 3'b100, 64'h10, 64'h0, 64'h0, 1'b1, 1, 0,
                 2, 64'h1122334455667788};
    vecs[13] = '{1'b1, 3'b001, 64'h3, 64'h000000000000BEEF, 64'h0, 1'b0, 3, 1,
                 0, 64'h012345BEEFABCDFF};

    rst_n          = 1'b0;
    pl_en          = 1'b0;
    pl_idx         = '0;
    pl_data        = '0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    // Reset values.
    #1;
    chk("rst req_ready",  64'(bus.req_ready),  64'd1);
    chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst resp_rdata", bus.resp_rdata,      64'd0);
    chk("rst resp_err",   64'(bus.resp_err),   64'd0);
    chk("rst mem_wen_n",  64'(bus.mem_wen_n),  64'd1);
    chk("rst mem_funct3", 64'(bus.mem_funct3), 64'd3);
    chk("rst mem_raddr",  bus.mem_raddr,       64'd0);
    chk("rst mem_waddr",  bus.mem_waddr,       64'd0);
    chk("rst mem_wdata",  bus.mem_wdata,       64'd0);

    for (int i = 0; i < 32; i++) preload(i, 64'h0);
    preload(0, 64'h0123456789ABCDEF);
    preload(31, 64'h8000000000000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, er, wr);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d resp_err", i), 64'(er), 64'(vecs[i].exp_err));
      if (!vecs[i].exp_err) chk($sformatf("v%0d resp_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d writes", i), 64'(wr), 64'(vecs[i].exp_wr));
      if (vecs[i].chk_idx >= 0)
        chk($sformatf("v%0d mem[%0d]", i, vecs[i].chk_idx), mem[vecs[i].chk_idx],
            vecs[i].chk_val);
    end

    // Backpressure: response held for 3 cycles, a competing request must be ignored.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = 64'h10;
    w0 = wr_count;
    @(posedge clk);
    #1;
    bus.req_store = 1'b1;
    bus.req_wdata = 64'h0;
    @(negedge clk);
    chk("bp busy req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("bp resp_valid", 64'(bus.resp_valid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d resp_valid", c), 64'(bus.resp_valid), 64'd1);
      chk($sformatf("bp hold%0d resp_rdata", c), bus.resp_rdata, 64'h1122334455667788);
      chk($sformatf("bp hold%0d req_ready", c), 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    chk("bp idle req_ready", 64'(bus.req_ready), 64'd1);
    chk("bp writes", 64'(wr_count - w0), 64'd0);
    chk("bp mem[2]", mem[2], 64'h1122334455667788);

    // Reset while in WR1 of a crossing store to 0x24 (words 4 and 5).
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = 64'h24;
    bus.req_wdata  = 64'h5555666677778888;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("wr1 mem_wen_n", 64'(bus.mem_wen_n), 64'd0);
    chk("wr1 mem_waddr", bus.mem_waddr, 64'd5);
    rst_n = 1'b0;
    #1;
    chk("arst mem_wen_n",  64'(bus.mem_wen_n),  64'd1);
    chk("arst req_ready",  64'(bus.req_ready),  64'd1);
    chk("arst resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("arst mem_waddr",  bus.mem_waddr,       64'd0);
    chk("arst mem_raddr",  bus.mem_raddr,       64'd0);
    chk("arst mem_wdata",  bus.mem_wdata,       64'd0);
    @(posedge clk);
    #1;
    chk("arst mem[4]", mem[4], 64'h777788880000AABB);
    chk("arst mem[5]", mem[5], 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Still functional after the reset.
    do_req(1'b0, 3'b100, 64'h24, 64'h0, lat, rd, er, wr);
    chk("post rst LBU latency", 64'(lat), 64'd2);
    chk("post rst LBU rdata", rd, 64'h88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
